// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default geometry.
package interrupt_pkg;

  localparam int unsigned DEF_NUM_IRQ       = 4;
  localparam int unsigned DEF_PC_WIDTH      = 32;
  localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0010;
  localparam int unsigned DEF_VECTOR_STRIDE = 4;

  typedef logic [1:0] irqState_t;

  localparam irqState_t IDLE      = 2'd0;
  localparam irqState_t WAIT_SAFE = 2'd1;
  localparam irqState_t TAKE      = 2'd2;
  localparam irqState_t IN_ISR    = 2'd3;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder; the lowest set index wins.
module irq_priority_encoder
  import interrupt_pkg::*;
#(
  parameter int unsigned NUM_IRQ = DEF_NUM_IRQ,
  parameter int unsigned ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] reqVec,
  output logic [ID_W-1:0]    winnerId,
  output logic               winnerValid
);

  // Scan from the top so the lowest index is the last (winning) assignment.
  always_comb begin
    winnerId    = '0;
    winnerValid = 1'b0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (reqVec[i]) begin
        winnerId    = ID_W'(i);
        winnerValid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, fixed-priority interrupt controller that waits for a pipeline-safe
// point, pulses a take to the hazard unit and presents vector/return PC to fetch.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int unsigned          NUM_IRQ       = DEF_NUM_IRQ,
  parameter int unsigned          PC_WIDTH      = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]  VECTOR_BASE   = PC_WIDTH'(DEF_VECTOR_BASE),
  parameter int unsigned          VECTOR_STRIDE = DEF_VECTOR_STRIDE,
  parameter int unsigned          ID_W          = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [NUM_IRQ-1:0]  i_IrqReq,
  input  logic [NUM_IRQ-1:0]  i_IrqMask,
  input  logic                i_GlobalEn,
  input  logic                i_StallSignal,
  input  logic                i_FlushDecode,
  input  logic                i_RetiBit,
  input  logic [PC_WIDTH-1:0] i_PcReturn,
  output logic                o_InterruptSignal,
  output logic                o_VectorValid,
  output logic [PC_WIDTH-1:0] o_VectorAddr,
  output logic [PC_WIDTH-1:0] o_SavedPc,
  output logic                o_InIsr,
  output logic [NUM_IRQ-1:0]  o_IrqAck,
  output logic [ID_W-1:0]     o_ActiveId,
  output logic [NUM_IRQ-1:0]  o_Pending
);

  irqState_t          state;
  irqState_t          nextState;
  logic               takeEntry;
  logic [NUM_IRQ-1:0] ackNext;

  logic [NUM_IRQ-1:0] prevReq;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clearMask;
  logic [NUM_IRQ-1:0] pendingNext;
  logic [ID_W-1:0]    winnerId;
  logic               winnerValid;
  logic               safe;

  assign rise      = i_IrqReq & ~prevReq;
  assign eligible  = i_GlobalEn ? (pending & i_IrqMask) : '0;
  assign safe      = !i_StallSignal && !i_FlushDecode && !i_RetiBit;
  // A new edge on the bit being acknowledged wins over its clear.
  assign clearMask   = (state == TAKE) ? o_IrqAck : '0;
  assign pendingNext = (pending & ~clearMask) | rise;

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prioEnc (
    .reqVec      (eligible),
    .winnerId    (winnerId),
    .winnerValid (winnerValid)
  );

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and take decode.
  always_comb begin
    nextState = state;
    takeEntry = 1'b0;
    ackNext   = '0;
    case (state)
      IDLE: begin
        if (winnerValid) nextState = WAIT_SAFE;
      end
      WAIT_SAFE: begin
        if (!winnerValid) begin
          nextState = IDLE;
        end else if (safe) begin
          nextState = TAKE;
          takeEntry = 1'b1;
          ackNext   = NUM_IRQ'(1) << winnerId;
        end
      end
      TAKE: begin
        nextState = IN_ISR;
      end
      IN_ISR: begin
        if (i_RetiBit) nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Request edge capture and pending bookkeeping.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      prevReq <= '0;
      pending <= '0;
    end else begin
      prevReq <= i_IrqReq;
      pending <= pendingNext;
    end
  end

  // Registered outputs; pulses are high exactly while the FSM sits in TAKE.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_InterruptSignal <= 1'b0;
      o_VectorValid     <= 1'b0;
      o_IrqAck          <= '0;
      o_InIsr           <= 1'b0;
      o_ActiveId        <= '0;
      o_SavedPc         <= '0;
    end else begin
      o_InterruptSignal <= takeEntry;
      o_VectorValid     <= takeEntry;
      o_IrqAck          <= ackNext;
      o_InIsr           <= (nextState == TAKE) || (nextState == IN_ISR);
      if (takeEntry) begin
        o_ActiveId <= winnerId;
        o_SavedPc  <= i_PcReturn;
      end
    end
  end

  assign o_Pending    = pending;
  assign o_VectorAddr = VECTOR_BASE + PC_WIDTH'(o_ActiveId) * PC_WIDTH'(VECTOR_STRIDE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: vector table plus hand-written
// multi-cycle sequences, with a scoreboard of expected takes.
module tb_interrupt_controller;

  logic        i_Clk;
  logic        i_Rst;
  logic [3:0]  i_IrqReq;
  logic [3:0]  i_IrqMask;
  logic        i_GlobalEn;
  logic        i_StallSignal;
  logic        i_FlushDecode;
  logic        i_RetiBit;
  logic [31:0] i_PcReturn;
  logic        o_InterruptSignal;
  logic        o_VectorValid;
  logic [31:0] o_VectorAddr;
  logic [31:0] o_SavedPc;
  logic        o_InIsr;
  logic [3:0]  o_IrqAck;
  logic [1:0]  o_ActiveId;
  logic [3:0]  o_Pending;

  interrupt_controller dut (
    .i_Clk             (i_Clk),
    .i_Rst             (i_Rst),
    .i_IrqReq          (i_IrqReq),
    .i_IrqMask         (i_IrqMask),
    .i_GlobalEn        (i_GlobalEn),
    .i_StallSignal     (i_StallSignal),
    .i_FlushDecode     (i_FlushDecode),
    .i_RetiBit         (i_RetiBit),
    .i_PcReturn        (i_PcReturn),
    .o_InterruptSignal (o_InterruptSignal),
    .o_VectorValid     (o_VectorValid),
    .o_VectorAddr      (o_VectorAddr),
    .o_SavedPc         (o_SavedPc),
    .o_InIsr           (o_InIsr),
    .o_IrqAck          (o_IrqAck),
    .o_ActiveId        (o_ActiveId),
    .o_Pending         (o_Pending)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [31:0] vec;
    logic [31:0] pc;
    logic [3:0]  ack;
    logic [1:0]  id;
  } expTake_t;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  mask;
    logic        gEn;
    logic [31:0] pc;
    logic        take;
    logic [1:0]  id;
  } vector_t;

  localparam int NVEC = 7;

  expTake_t sbQ[$];
  vector_t  vecs[NVEC];
  int       tests = 0;
  int       fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [1:0] id, input logic [31:0] pc);
    expTake_t e;
    e.id  = id;
    e.pc  = pc;
    e.vec = 32'h10 + 32'(id) * 32'd4;
    e.ack = 4'b0001 << id;
    sbQ.push_back(e);
  endtask

  // Advance one cycle, sample after the edge, and retire any take into the scoreboard.
  task automatic step();
    expTake_t e;
    @(posedge i_Clk);
    #1;
    if (o_VectorValid === 1'b1) begin
      if (sbQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got take id %0d, expected none (t=%0t)", o_ActiveId, $time);
      end else begin
        e = sbQ.pop_front();
        chk("sb_vec", 64'(o_VectorAddr), 64'(e.vec));
        chk("sb_pc", 64'(o_SavedPc), 64'(e.pc));
        chk("sb_ack", 64'(o_IrqAck), 64'(e.ack));
        chk("sb_id", 64'(o_ActiveId), 64'(e.id));
      end
    end
  endtask

  task automatic expectTake(input int n, input string nm);
    for (int i = 0; i < n - 1; i++) begin
      step();
      chk({nm, "_early"}, 64'(o_InterruptSignal), 64'd0);
    end
    step();
    chk(nm, 64'({o_InterruptSignal, o_VectorValid, o_InIsr}), 64'(3'b111));
  endtask

  task automatic checkResetVals(input string nm);
    chk({nm, "_ctl"}, 64'({o_InterruptSignal, o_VectorValid, o_InIsr, o_IrqAck, o_ActiveId, o_Pending}), 64'd0);
    chk({nm, "_vec"}, 64'(o_VectorAddr), 64'h10);
    chk({nm, "_spc"}, 64'(o_SavedPc), 64'd0);
  endtask

  task automatic resetDut();
    i_IrqReq      = '0;
    i_IrqMask     = 4'hF;
    i_GlobalEn    = 1'b1;
    i_StallSignal = 1'b0;
    i_FlushDecode = 1'b0;
    i_RetiBit     = 1'b0;
    i_PcReturn    = '0;
    i_Rst         = 1'b0;
    step();
    step();
    i_Rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0100, 4'hF,    1'b1, 32'h100, 1'b1, 2'd2};
    vecs[1] = '{4'b0001, 4'hF,    1'b1, 32'h200, 1'b1, 2'd0};
    vecs[2] = '{4'b1000, 4'hF,    1'b1, 32'h300, 1'b1, 2'd3};
    vecs[3] = '{4'b1010, 4'hF,    1'b1, 32'h400, 1'b1, 2'd1};
    vecs[4] = '{4'b0010, 4'b1101, 1'b1, 32'h500, 1'b0, 2'd0};
    vecs[5] = '{4'b0001, 4'hF,    1'b0, 32'h600, 1'b0, 2'd0};
    vecs[6] = '{4'b1100, 4'b0111, 1'b1, 32'h700, 1'b1, 2'd2};

    i_Rst = 1'b0;
    resetDut();
    checkResetVals("reset");

    // Table: one request pattern per reset, take checked at minimum latency.
    for (int v = 0; v < NVEC; v++) begin
      logic [3:0] ack;
      resetDut();
      ack        = vecs[v].take ? (4'b0001 << vecs[v].id) : 4'b0000;
      i_IrqMask  = vecs[v].mask;
      i_GlobalEn = vecs[v].gEn;
      i_PcReturn = vecs[v].pc;
      i_IrqReq   = vecs[v].req;
      if (vecs[v].take) pushExp(vecs[v].id, vecs[v].pc);
      step();
      i_IrqReq = '0;
      step();
      chk("vec_early", 64'(o_InterruptSignal), 64'd0);
      step();
      chk("vec_int", 64'({o_InterruptSignal, o_VectorValid}), 64'({vecs[v].take, vecs[v].take}));
      chk("vec_ack", 64'(o_IrqAck), 64'(ack));
      chk("vec_pend", 64'(o_Pending), 64'(vecs[v].req));
      if (vecs[v].take) begin
        chk("vec_addr", 64'(o_VectorAddr), 64'(32'h10 + 32'(vecs[v].id) * 32'd4));
        chk("vec_spc", 64'(o_SavedPc), 64'(vecs[v].pc));
      end
      step();
      chk("vec_after", 64'({o_InterruptSignal, o_InIsr, o_Pending}),
          64'({1'b0, vecs[v].take, vecs[v].req & ~ack}));
    end

    // Priority: IRQ1 first, IRQ3 after RETI.
    resetDut();
    i_PcReturn = 32'h60;
    i_IrqReq   = 4'b1010;
    pushExp(2'd1, 32'h60);
    step();
    i_IrqReq = '0;
    expectTake(2, "prio_first");
    step();
    chk("prio_pend3", 64'(o_Pending), 64'(4'b1000));
    i_RetiBit  = 1'b1;
    i_PcReturn = 32'h64;
    step();
    i_RetiBit = 1'b0;
    pushExp(2'd3, 32'h64);
    expectTake(2, "prio_second");
    chk("prio_vec3", 64'(o_VectorAddr), 64'h1C);

    // Stall hold-off for 5 cycles in WAIT_SAFE.
    resetDut();
    i_StallSignal = 1'b1;
    i_PcReturn    = 32'h40;
    i_IrqReq      = 4'b0100;
    step();
    i_IrqReq = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", 64'({o_InterruptSignal, o_InIsr}), 64'd0);
      i_PcReturn = i_PcReturn + 32'd4;
    end
    i_StallSignal = 1'b0;
    pushExp(2'd2, i_PcReturn);
    expectTake(1, "stall_take");
    chk("stall_spc", 64'(o_SavedPc), 64'h54);

    // Mask drop in WAIT_SAFE, then unmask.
    resetDut();
    i_StallSignal = 1'b1;
    i_IrqReq      = 4'b0001;
    step();
    i_IrqReq = '0;
    step();
    step();
    i_IrqMask = 4'b1110;
    step();
    chk("mask_drop", 64'({o_InterruptSignal, o_InIsr, o_Pending}), 64'(6'b000001));
    i_StallSignal = 1'b0;
    step();
    step();
    chk("mask_idle", 64'(o_InterruptSignal), 64'd0);
    i_IrqMask  = 4'hF;
    i_PcReturn = 32'h80;
    pushExp(2'd0, 32'h80);
    expectTake(2, "mask_take");

    // No nesting: edge during IN_ISR waits for RETI.
    step();
    i_IrqReq = 4'b0001;
    step();
    i_IrqReq = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nest_hold", 64'({o_InterruptSignal, o_InIsr}), 64'(2'b01));
    end
    chk("nest_pend", 64'(o_Pending), 64'(4'b0001));
    i_RetiBit  = 1'b1;
    i_PcReturn = 32'h90;
    step();
    i_RetiBit = 1'b0;
    pushExp(2'd0, 32'h90);
    expectTake(2, "nest_take");

    // Coincident edge in TAKE keeps the bit pending; a held request fires once.
    resetDut();
    i_PcReturn = 32'hA0;
    i_IrqReq   = 4'b0010;
    pushExp(2'd1, 32'hA0);
    step();
    i_IrqReq = '0;
    expectTake(2, "coin_take");
    i_IrqReq = 4'b0010;
    step();
    chk("coin_pend", 64'(o_Pending), 64'(4'b0010));
    i_RetiBit = 1'b1;
    step();
    i_RetiBit = 1'b0;
    pushExp(2'd1, 32'hA0);
    expectTake(2, "coin_retake");
    step();
    i_RetiBit = 1'b1;
    step();
    i_RetiBit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_once", 64'({o_InterruptSignal, o_InIsr}), 64'd0);
    end
    chk("held_pend", 64'(o_Pending), 64'd0);

    // Asynchronous reset in IN_ISR, then a stray RETI.
    resetDut();
    i_PcReturn = 32'hC0;
    i_IrqReq   = 4'b1000;
    pushExp(2'd3, 32'hC0);
    step();
    i_IrqReq = '0;
    expectTake(2, "rst_take");
    step();
    i_IrqReq = 4'b0001;
    step();
    chk("rst_inisr", 64'({o_InIsr, o_Pending}), 64'(5'b10001));
    i_IrqReq = '0;
    i_Rst    = 1'b0;
    #2;
    checkResetVals("rst_async");
    step();
    i_Rst     = 1'b1;
    i_RetiBit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_reti", 64'({o_InterruptSignal, o_InIsr, o_Pending}), 64'd0);
    end
    i_RetiBit = 1'b0;

    chk("sb_drain", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
